// File: rtl/hazard_fwd_unit_pkg.sv
// Shared encodings and slot layout for the hazard/forwarding unit.
// Optional statistics counters are enabled by defining HAZARD_STATS_EN.
package hazard_fwd_unit_pkg;

  localparam int unsigned FWD_SEL_W = 2;
  localparam int unsigned STAT_W    = 16;

  typedef enum logic [FWD_SEL_W-1:0] {
    FWD_RF = 2'd0,
    FWD_W  = 2'd1,
    FWD_M  = 2'd2,
    FWD_X  = 2'd3
  } fwd_sel_e;

  // Per-slot flags; the destination field is kept separately because its width is a parameter.
  typedef struct packed {
    logic valid;
    logic wen;
    logic is_load;
  } slot_flags_t;

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// D-stage request, bypass data and hazard/forwarding results between the pipeline and the unit.
interface hazard_fwd_unit_if #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned REG_AW  = 3,
  parameter int unsigned NUM_SRC = 2
);
  import hazard_fwd_unit_pkg::*;

  logic                        d_valid;
  logic [NUM_SRC*REG_AW-1:0]   d_src;
  logic [NUM_SRC-1:0]          d_src_use;
  logic                        d_wen;
  logic [REG_AW-1:0]           d_dest;
  logic                        d_is_load;
  logic [NUM_SRC*DATA_W-1:0]   d_rf_data;
  logic [DATA_W-1:0]           x_data;
  logic [DATA_W-1:0]           m_data;
  logic [DATA_W-1:0]           w_data;
  logic                        flush;
  logic                        mem_wait;
  logic                        stall;
  logic                        freeze;
  logic [NUM_SRC*DATA_W-1:0]   opnd;
  logic [NUM_SRC*FWD_SEL_W-1:0] fwd_sel;

  modport master (
    output d_valid, d_src, d_src_use, d_wen, d_dest, d_is_load, d_rf_data,
    output x_data, m_data, w_data, flush, mem_wait,
    input  stall, freeze, opnd, fwd_sel
  );

  modport slave (
    input  d_valid, d_src, d_src_use, d_wen, d_dest, d_is_load, d_rf_data,
    input  x_data, m_data, w_data, flush, mem_wait,
    output stall, freeze, opnd, fwd_sel
  );
endinterface

// File: rtl/hazard_fwd_unit_slot.sv
// One in-flight writer tracking slot: clears on reset, loads when enabled, otherwise holds.
module hazard_fwd_unit_slot
  import hazard_fwd_unit_pkg::*;
#(
  parameter int unsigned REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  slot_flags_t       flags_i,
  input  logic [REG_AW-1:0] dest_i,
  output slot_flags_t       flags_o,
  output logic [REG_AW-1:0] dest_o
);

  slot_flags_t       flags_q;
  logic [REG_AW-1:0] dest_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
      dest_q  <= '0;
    end else if (en_i) begin
      flags_q <= flags_i;
      dest_q  <= dest_i;
    end
  end

  assign flags_o = flags_q;
  assign dest_o  = dest_q;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding unit for the 5-stage pipe: tracks X/M/W writers, bypasses D operands,
// raises load-use stall and freezes on memory wait. HAZARD_STATS_EN adds stall/forward counters.
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned REG_AW  = 3,
  parameter int unsigned NUM_SRC = 2
) (
  input  logic               clk,
  input  logic               rst,
  hazard_fwd_unit_if.slave   bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0]  stall_cnt,
  output logic [STAT_W-1:0]  fwd_cnt
`endif
);

  localparam int unsigned SEL_W = FWD_SEL_W;

  logic                       advance;
  logic                       stall_c;
  logic [NUM_SRC-1:0]         ld_hit;
  logic [NUM_SRC*SEL_W-1:0]   fwd_sel_c;
  logic [NUM_SRC*DATA_W-1:0]  opnd_c;

  slot_flags_t       x_flags_d, x_flags_q, m_flags_q, w_flags_q;
  logic [REG_AW-1:0] x_dest_d, x_dest_q, m_dest_q, w_dest_q;

  assign advance = ~bus.mem_wait;

  // A stalled or flushed D instruction enters X as a bubble.
  always_comb begin
    x_flags_d = '0;
    x_dest_d  = '0;
    if (bus.d_valid & ~stall_c & ~bus.flush) begin
      x_flags_d.valid   = 1'b1;
      x_flags_d.wen     = bus.d_wen;
      x_flags_d.is_load = bus.d_is_load;
      x_dest_d          = bus.d_dest;
    end
  end

  hazard_fwd_unit_slot #(.REG_AW(REG_AW)) u_slot_x (
    .clk(clk), .rst(rst), .en_i(advance),
    .flags_i(x_flags_d), .dest_i(x_dest_d), .flags_o(x_flags_q), .dest_o(x_dest_q)
  );

  hazard_fwd_unit_slot #(.REG_AW(REG_AW)) u_slot_m (
    .clk(clk), .rst(rst), .en_i(advance),
    .flags_i(x_flags_q), .dest_i(x_dest_q), .flags_o(m_flags_q), .dest_o(m_dest_q)
  );

  hazard_fwd_unit_slot #(.REG_AW(REG_AW)) u_slot_w (
    .clk(clk), .rst(rst), .en_i(advance),
    .flags_i(m_flags_q), .dest_i(m_dest_q), .flags_o(w_flags_q), .dest_o(w_dest_q)
  );

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_AW-1:0] src;
    logic              hit_x, hit_m, hit_w;
    fwd_sel_e          sel;
    logic [DATA_W-1:0] val;

    assign src   = bus.d_src[i*REG_AW +: REG_AW];
    assign hit_x = x_flags_q.valid & x_flags_q.wen & bus.d_src_use[i] & (x_dest_q == src);
    assign hit_m = m_flags_q.valid & m_flags_q.wen & bus.d_src_use[i] & (m_dest_q == src);
    assign hit_w = w_flags_q.valid & w_flags_q.wen & bus.d_src_use[i] & (w_dest_q == src);
    assign ld_hit[i] = hit_x & x_flags_q.is_load;

    // Youngest producer wins; a load still in X cannot supply data, so fall through to older ones.
    always_comb begin
      sel = FWD_RF;
      if (hit_x & ~x_flags_q.is_load) sel = FWD_X;
      else if (hit_m)                 sel = FWD_M;
      else if (hit_w)                 sel = FWD_W;
    end

    always_comb begin
      val = bus.d_rf_data[i*DATA_W +: DATA_W];
      case (sel)
        FWD_X:   val = bus.x_data;
        FWD_M:   val = bus.m_data;
        FWD_W:   val = bus.w_data;
        default: val = bus.d_rf_data[i*DATA_W +: DATA_W];
      endcase
    end

    assign fwd_sel_c[i*SEL_W +: SEL_W] = sel;
    assign opnd_c[i*DATA_W +: DATA_W]  = val;
  end

  assign stall_c     = bus.d_valid & ~bus.flush & (|ld_hit);
  assign bus.stall   = stall_c;
  assign bus.freeze  = bus.mem_wait;
  assign bus.fwd_sel = fwd_sel_c;
  assign bus.opnd    = opnd_c;

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_d, stall_cnt_q, fwd_cnt_d, fwd_cnt_q;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall_c & advance & (stall_cnt_q != {STAT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + STAT_W'(1);
    if (advance & (|fwd_sel_c) & (fwd_cnt_q != {STAT_W{1'b1}}))
      fwd_cnt_d = fwd_cnt_q + STAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed vector table, hand sequences, random vs. model.
module tb_hazard_fwd_unit;
  import hazard_fwd_unit_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;
  localparam int unsigned NS = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_fwd_unit_if #(.DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS)) bus ();

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt, fwd_cnt;
`endif

  hazard_fwd_unit #(.DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt(stall_cnt),
    .fwd_cnt(fwd_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference: list of in-flight instructions ordered by age, [0] youngest (in X).
  typedef struct {
    bit valid;
    bit wen;
    bit is_load;
    int dest;
  } ent_t;
  ent_t pipe[3];

  bit exp_stall;
  int exp_sel[NS];

  typedef struct {
    bit v; int s0; int s1; bit [1:0] su; bit wen; int dest; bit ld; bit fl;
    bit st; int e0; int e1;
  } row_t;
  row_t tbl[16];

  function automatic row_t mk(bit v, int s0, int s1, bit [1:0] su, bit wen, int dest, bit ld,
                              bit fl, bit st, int e0, int e1);
    row_t r;
    r.v = v; r.s0 = s0; r.s1 = s1; r.su = su; r.wen = wen; r.dest = dest; r.ld = ld; r.fl = fl;
    r.st = st; r.e0 = e0; r.e1 = e1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int src_of(int i);
    logic [NS*AW-1:0] v;
    v = bus.d_src;
    return int'(v[i*AW +: AW]);
  endfunction

  // Expected outputs from the current in-flight list and D inputs.
  function automatic void model_outputs();
    bit any_ld = 1'b0;
    for (int i = 0; i < NS; i++) begin
      exp_sel[i] = 0;
      if (bus.d_src_use[i]) begin
        for (int age = 0; age < 3; age++) begin
          if (pipe[age].valid && pipe[age].wen && pipe[age].dest == src_of(i)) begin
            if (age == 0 && pipe[age].is_load) begin
              any_ld = 1'b1;
            end else begin
              exp_sel[i] = 3 - age;
              break;
            end
          end
        end
      end
    end
    exp_stall = bus.d_valid && !bus.flush && any_ld;
  endfunction

  function automatic void model_clock();
    ent_t e;
    if (rst) begin
      for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
    end else if (!bus.mem_wait) begin
      e = '{default: 0};
      if (bus.d_valid && !exp_stall && !bus.flush) begin
        e.valid = 1'b1; e.wen = bus.d_wen; e.is_load = bus.d_is_load; e.dest = int'(bus.d_dest);
      end
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = e;
    end
  endfunction

  function automatic logic [DW-1:0] pick(int sel, int i);
    logic [NS*DW-1:0] rf;
    rf = bus.d_rf_data;
    case (sel)
      3:       return bus.x_data;
      2:       return bus.m_data;
      1:       return bus.w_data;
      default: return rf[i*DW +: DW];
    endcase
  endfunction

  task automatic drive(bit v, int s0, int s1, bit [1:0] su, bit wen, int dest, bit ld, bit fl,
                       bit mw);
    bus.d_valid   = v;
    bus.d_src     = {AW'(s1), AW'(s0)};
    bus.d_src_use = su;
    bus.d_wen     = wen;
    bus.d_dest    = AW'(dest);
    bus.d_is_load = ld;
    bus.flush     = fl;
    bus.mem_wait  = mw;
  endtask

  task automatic fixed_data();
    bus.d_rf_data = {16'hB1B1, 16'hA0A0};
    bus.x_data    = 16'h1234;
    bus.m_data    = 16'hBEEF;
    bus.w_data    = 16'h5555;
  endtask

  // Check one cycle (inputs already driven, clock low), then clock it into DUT and model.
  task automatic apply(input string tag, input bit use_model, input bit st, input int e0,
                       input int e1);
    logic [NS*2-1:0]  sel_v;
    logic [NS*DW-1:0] op_v;
    int e[NS];
    model_outputs();
    if (use_model) begin
      st = exp_stall; e[0] = exp_sel[0]; e[1] = exp_sel[1];
    end else begin
      e[0] = e0; e[1] = e1;
    end
    #1;
    sel_v = bus.fwd_sel;
    op_v  = bus.opnd;
    chk({tag, " stall"}, 32'(bus.stall), 32'(st));
    chk({tag, " freeze"}, 32'(bus.freeze), 32'(bus.mem_wait));
    for (int i = 0; i < NS; i++) begin
      chk($sformatf("%s sel%0d", tag, i), 32'(sel_v[i*2 +: 2]), 32'(e[i]));
      chk($sformatf("%s opnd%0d", tag, i), 32'(op_v[i*DW +: DW]), 32'(pick(e[i], i)));
    end
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    fixed_data();
    drive(1, 1, 2, 2'b11, 1, 1, 0, 0, 0);
    @(negedge clk);
    apply("reset", 0, 0, 0, 0);
    apply("reset2", 0, 0, 0, 0);
    rst = 1'b0;

    //        v  s0 s1 su     wen dst ld fl  st e0 e1
    tbl[0]  = mk(1, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 2'b01, 1, 4, 0, 0, 0, 3, 0);
    tbl[2]  = mk(1, 0, 0, 2'b00, 1, 2, 1, 0, 0, 0, 0);
    tbl[3]  = mk(1, 1, 2, 2'b11, 1, 5, 0, 0, 1, 1, 0);
    tbl[4]  = mk(1, 1, 2, 2'b11, 1, 5, 0, 0, 0, 0, 2);
    tbl[5]  = mk(1, 0, 0, 2'b00, 1, 3, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 0, 0, 2'b00, 1, 6, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 3, 0, 2'b01, 1, 3, 0, 0, 0, 1, 0);
    tbl[9]  = mk(1, 0, 0, 2'b00, 1, 7, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 0, 0, 2'b00, 1, 3, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 7, 3, 2'b11, 0, 0, 0, 0, 0, 2, 3);
    tbl[12] = mk(0, 7, 3, 2'b11, 0, 0, 0, 0, 0, 1, 2);
    tbl[13] = mk(1, 0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0);
    tbl[14] = mk(1, 0, 0, 2'b01, 0, 0, 0, 1, 0, 0, 0);
    tbl[15] = mk(1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 2, 0);
    for (int r = 0; r < 16; r++) begin
      drive(tbl[r].v, tbl[r].s0, tbl[r].s1, tbl[r].su, tbl[r].wen, tbl[r].dest, tbl[r].ld,
            tbl[r].fl, 0);
      apply($sformatf("row%0d", r), 0, tbl[r].st, tbl[r].e0, tbl[r].e1);
    end

    // Load-use held across a 3-cycle memory wait, then a single stall after release.
    rst = 1'b1; drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0); apply("mw_rst", 0, 0, 0, 0);
    rst = 1'b0;
    drive(1, 0, 0, 2'b00, 1, 2, 1, 0, 0); apply("mw_ld", 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 2, 2'b10, 0, 0, 0, 0, 1); apply($sformatf("mw_wait%0d", k), 0, 1, 0, 0);
    end
    drive(1, 0, 2, 2'b10, 0, 0, 0, 0, 0); apply("mw_stall", 0, 1, 0, 0);
    apply("mw_fwdM", 0, 0, 0, 2);
    apply("mw_fwdW", 0, 0, 0, 1);

    // Reset mid-operation: outputs still follow slots this cycle, forwarding lost afterwards.
    drive(1, 0, 0, 2'b00, 1, 1, 0, 0, 0); apply("rst_wr", 0, 0, 0, 0);
    rst = 1'b1; drive(1, 1, 0, 2'b01, 0, 0, 0, 0, 0); apply("rst_mid", 0, 0, 3, 0);
    rst = 1'b0; apply("rst_after", 0, 0, 0, 0);

    // Randomized traffic checked against the reference list.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(63) == 0);
      drive($urandom_range(3) != 0, $urandom_range(7), $urandom_range(7), 2'($urandom_range(3)),
            $urandom_range(3) != 0, $urandom_range(7), $urandom_range(2) == 0,
            $urandom_range(7) == 0, $urandom_range(4) == 0);
      bus.d_rf_data = {16'($urandom), 16'($urandom)};
      bus.x_data    = 16'($urandom);
      bus.m_data    = 16'($urandom);
      bus.w_data    = 16'($urandom);
      apply($sformatf("rnd%0d", n), 1, 0, 0, 0);
    end
    rst = 1'b0;
    fixed_data();

`ifdef HAZARD_STATS_EN
    rst = 1'b1; drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0); apply("st_rst", 0, 0, 0, 0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 2'b00, 1, 2, 1, 0, 0); apply("st_ld", 1, 0, 0, 0);
      drive(1, 2, 0, 2'b01, 0, 0, 0, 0, 0); apply("st_use", 1, 0, 0, 0);
      apply("st_go", 1, 0, 0, 0);
    end
    #1 chk("stall_cnt5", 32'(stall_cnt), 32'd5);
    rst = 1'b1; drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0); apply("st_rst2", 0, 0, 0, 0);
    rst = 1'b0;
    #1 chk("stall_cnt_rst", 32'(stall_cnt), 32'd0);
    chk("fwd_cnt_rst", 32'(fwd_cnt), 32'd0);
    // Back-to-back dependent writes to r1 forward every advancing cycle.
    drive(1, 1, 0, 2'b01, 1, 1, 0, 0, 0);
    for (int k = 0; k < 65540; k++) begin
      @(posedge clk);
    end
    @(negedge clk);
    chk("fwd_cnt_sat", 32'(fwd_cnt), 32'h0000FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
